// File: rtl/bit_assembler.sv
// bit_assembler: rebuilds a WIDTH-bit mask from a serial stream of bit
// indices. A frame ends on the beat flagged last. One cycle after that beat
// the block presents the assembled word, its popcount and an error flag,
// with a one-cycle valid pulse.
// Optional feature macro: BIT_ASSEMBLER_CHECK_EN enables duplicate and
// out-of-range detection on err_o. When the macro is undefined, err_o is 0.
module bit_assembler #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             idx_val_i,
  input  logic             idx_last_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] data_cnt_o,
  output logic             data_val_o,
  output logic             err_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic             issue;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] onehot;
  logic             in_range;
  logic             hit;
  logic             is_new;
  logic [WIDTH-1:0] acc_beat;
  logic [CNT_W-1:0] cnt_beat;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] data_cnt_q;
  logic             data_val_q;

  // Decode the current beat into the accumulator and popcount it would produce.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    onehot   = '0;
    in_range = int'(idx_i) < WIDTH;
    if (in_range) onehot[idx_i] = 1'b1;
    hit      = |(acc_q & onehot);
    is_new   = in_range && !hit;
    acc_beat = acc_q | onehot;
    cnt_beat = cnt_q + CNT_W'(is_new);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the edge.
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and result-issue decode; flush wins over any same-cycle beat.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else if (idx_val_i) begin
      if (idx_last_i) begin
        issue   = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = COLLECT;
      end
    end
  end

  // Accumulator, popcount and registered result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      data_cnt_q <= '0;
      data_val_q <= 1'b0;
    end else begin
      data_val_q <= issue;
      if (flush_i) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (issue) begin
        data_q     <= acc_beat;
        data_cnt_q <= cnt_beat;
        acc_q      <= '0;
        cnt_q      <= '0;
      end else if (idx_val_i) begin
        acc_q <= acc_beat;
        cnt_q <= cnt_beat;
      end
    end
  end

`ifdef BIT_ASSEMBLER_CHECK_EN
  logic err_q;
  logic err_out_q;
  logic err_beat;

  // Sticky frame error: an index that was already set or lies past the word.
  always_comb begin
    err_beat = err_q | !in_range | hit;
  end

  // Error flag for the frame in progress and for the last issued result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else if (flush_i) begin
      err_q <= 1'b0;
    end else if (issue) begin
      err_out_q <= err_beat;
      err_q     <= 1'b0;
    end else if (idx_val_i) begin
      err_q <= err_beat;
    end
  end

  assign err_o = err_out_q;
`else
  assign err_o = 1'b0;
`endif

  assign data_o     = data_q;
  assign data_cnt_o = data_cnt_q;
  assign data_val_o = data_val_q;
  assign busy_o     = (state_q == COLLECT);

endmodule
